// File: rtl/gameover_draw_ctrl.sv
// rtl/gameover_draw_ctrl.sv - game-over screen sequencer: framebuffer blank, text pass, completion/timeout
module gameover_draw_ctrl #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000,
  parameter int         MAX_DRAW    = 512
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       drawer_draw,
  input  logic [7:0] drawer_x,
  input  logic [6:0] drawer_y,
  input  logic [2:0] drawer_color,
  input  logic       drawer_finish,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int              WD_W    = (MAX_DRAW > 1) ? $clog2(MAX_DRAW) : 1;
  localparam logic [7:0]      X_LAST  = 8'(SCREEN_W - 1);
  localparam logic [6:0]      Y_LAST  = 7'(SCREEN_H - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_DRAW - 1);

  state_t          state_q, state_d;
  logic [7:0]      cx_q, cx_d;
  logic [6:0]      cy_q, cy_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      col_q, col_d;
  logic            plot_q, plot_d;
  logic            draw_q, draw_d;
  logic            tmo_q, tmo_d;

  // Next-state and datapath: raster sweep in CLEAR, one-cycle forwarding of the drawer stream in DRAW/FLUSH
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    draw_d  = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cx_d    = 8'd0;
          cy_d    = 7'd0;
          tmo_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        x_d    = cx_q;
        y_d    = cy_q;
        col_d  = CLEAR_COLOR;
        plot_d = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = 8'd0;
          if (cy_q == Y_LAST) begin
            cy_d    = 7'd0;
            wd_d    = '0;
            state_d = S_DRAW;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DRAW: begin
        // draw_q lags the enable by one cycle, matching the drawer's output register
        draw_d = 1'b1;
        x_d    = drawer_x;
        y_d    = drawer_y;
        col_d  = drawer_color;
        plot_d = draw_q;
        wd_d   = wd_q + 1'b1;
        if (drawer_finish) begin
          state_d = S_FLUSH;
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The drawer is paused now; its register still holds the final pixel
        x_d     = drawer_x;
        y_d     = drawer_y;
        col_d   = drawer_color;
        plot_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cx_q    <= 8'd0;
      cy_q    <= 7'd0;
      wd_q    <= '0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
      draw_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      draw_q  <= draw_d;
      tmo_q   <= tmo_d;
    end
  end

  assign drawer_draw = (state_q == S_DRAW);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign timeout     = tmo_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_color   = col_q;
  assign vga_plot    = plot_q;

endmodule
